// File: rtl/logic_seq_detect.sv
// logic_seq_detect
//   Serial bit-pattern detector. Accepted bits (iEN=1) shift into a
//   PATTERN_W-bit history register. A fill counter tracks how many bits
//   have been accepted since reset or since the last restart. A match
//   fires when the would-be next history equals PATTERN and the fill count
//   reaches PATTERN_W.
//   The match is reported as a registered one-cycle strobe. A saturating
//   match counter and a sticky overflow flag travel with it.
//
// Parameters
//   PATTERN_W  pattern length in bits (legal range 2..16)
//   PATTERN    pattern value, MSB is the first bit received
//   OVERLAP    1: keep history after a match; 0: restart fill after a match
//   CNT_W      width of the match counter
//
// Ports
//   iCLK    in   system clock, rising edge
//   iRST    in   asynchronous active-low reset
//   iEN     in   bit-valid qualifier, iIN is sampled only when high
//   iIN     in   serial data bit
//   iCLR    in   synchronous clear of oCOUNT and oOVF
//   oMATCH  out  one-cycle strobe, the cycle after the final pattern bit
//   oCOUNT  out  saturating match count since reset or clear
//   oOVF    out  sticky: a match arrived while oCOUNT was saturated
module logic_seq_detect #(
   parameter int                   PATTERN_W = 3,
   parameter logic [PATTERN_W-1:0] PATTERN   = 3'b101,
   parameter bit                   OVERLAP   = 1'b1,
   parameter int                   CNT_W     = 8
) (
   input  logic             iCLK,
   input  logic             iRST,
   input  logic             iEN,
   input  logic             iIN,
   input  logic             iCLR,
   output logic             oMATCH,
   output logic [CNT_W-1:0] oCOUNT,
   output logic             oOVF
);

   // The fill counter must be able to hold the value PATTERN_W itself.
   localparam int                 FILL_W    = $clog2(PATTERN_W + 1);
   localparam logic [FILL_W-1:0]  FILL_FULL = FILL_W'(PATTERN_W);
   localparam logic [CNT_W-1:0]   CNT_MAX   = '1;

   logic [PATTERN_W-1:0] hist_q,  hist_d;
   logic [FILL_W-1:0]    fill_q,  fill_d;
   logic                 match_q, match_d;
   logic [CNT_W-1:0]     count_q, count_d;
   logic                 ovf_q,   ovf_d;

   // Would-be next history and fill if the current bit is accepted.
   logic [PATTERN_W-1:0] hist_shift;
   logic [FILL_W-1:0]    fill_inc;

   always_comb begin
      hist_shift = {hist_q[PATTERN_W-2:0], iIN};
      fill_inc   = (fill_q == FILL_FULL) ? fill_q : fill_q + FILL_W'(1);

      hist_d  = hist_q;
      fill_d  = fill_q;
      match_d = 1'b0;
      count_d = count_q;
      ovf_d   = ovf_q;

      if (iEN) begin
         hist_d  = hist_shift;
         fill_d  = fill_inc;
         // The fill gate stops a partial history (for example an all-zero
         // pattern straight out of reset) from matching.
         match_d = (fill_inc == FILL_FULL) && (hist_shift == PATTERN);
      end

      // Non-overlapping mode needs PATTERN_W fresh bits after every match.
      // The stale history is harmless because the fill gate masks it.
      if (match_d && !OVERLAP) begin
         fill_d = '0;
      end

      // Clear takes priority over a coincident match. The strobe still fires.
      if (iCLR) begin
         count_d = '0;
         ovf_d   = 1'b0;
      end else if (match_d) begin
         if (count_q == CNT_MAX) begin
            ovf_d = 1'b1;
         end else begin
            count_d = count_q + CNT_W'(1);
         end
      end
   end

   always_ff @(posedge iCLK or negedge iRST) begin
      if (!iRST) begin
         hist_q  <= '0;
         fill_q  <= '0;
         match_q <= 1'b0;
         count_q <= '0;
         ovf_q   <= 1'b0;
      end else begin
         hist_q  <= hist_d;
         fill_q  <= fill_d;
         match_q <= match_d;
         count_q <= count_d;
         ovf_q   <= ovf_d;
      end
   end

   assign oMATCH = match_q;
   assign oCOUNT = count_q;
   assign oOVF   = ovf_q;

endmodule

// File: tb/tb_logic_seq_detect.sv
// Bench for logic_seq_detect. Four instances share one input stream:
//   0: defaults (3'b101, overlapping, 8-bit count)
//   1: 3'b101, non-overlapping
//   2: 3'b101, overlapping, 2-bit count (saturation / overflow)
//   3: 4'b0000, overlapping (all-zero pattern gated by fill)
// Every driven edge pushes the expected outputs of each instance to a
// queue. A monitor pops the queue and compares one cycle later.
module tb_logic_seq_detect;

   localparam int NI = 4;
   localparam int          PW   [NI] = '{3, 3, 3, 4};
   localparam logic [15:0] PAT  [NI] = '{16'h5, 16'h5, 16'h5, 16'h0};
   localparam bit          OVL  [NI] = '{1'b1, 1'b0, 1'b1, 1'b1};
   localparam int          MAXC [NI] = '{255, 255, 3, 255};

   logic iCLK = 1'b0;
   logic iRST;
   logic iEN;
   logic iIN;
   logic iCLR;

   logic       match_w [NI];
   logic [7:0] cnt_w   [NI];
   logic       ovf_w   [NI];
   logic [1:0] cnt_small;

   int tests_run    = 0;
   int tests_failed = 0;

   // Packed expectation: {match, ovf, count[7:0]}
   logic [9:0] exp_q [NI][$];
   logic [9:0] mon_e;

   // Reference state: accepted bits since restart, matches since clear
   bit hist_m     [NI][$];
   int since_clr_m[NI];

   // ---------------- clock / reset / DUTs ----------------
   always #5 iCLK = ~iCLK;

   logic_seq_detect u_dut0 (
      .iCLK(iCLK), .iRST(iRST), .iEN(iEN), .iIN(iIN), .iCLR(iCLR),
      .oMATCH(match_w[0]), .oCOUNT(cnt_w[0]), .oOVF(ovf_w[0]));

   logic_seq_detect #(.PATTERN_W(3), .PATTERN(3'b101), .OVERLAP(1'b0), .CNT_W(8)) u_dut1 (
      .iCLK(iCLK), .iRST(iRST), .iEN(iEN), .iIN(iIN), .iCLR(iCLR),
      .oMATCH(match_w[1]), .oCOUNT(cnt_w[1]), .oOVF(ovf_w[1]));

   logic_seq_detect #(.PATTERN_W(3), .PATTERN(3'b101), .OVERLAP(1'b1), .CNT_W(2)) u_dut2 (
      .iCLK(iCLK), .iRST(iRST), .iEN(iEN), .iIN(iIN), .iCLR(iCLR),
      .oMATCH(match_w[2]), .oCOUNT(cnt_small), .oOVF(ovf_w[2]));

   assign cnt_w[2] = {6'b0, cnt_small};

   logic_seq_detect #(.PATTERN_W(4), .PATTERN(4'b0000), .OVERLAP(1'b1), .CNT_W(8)) u_dut3 (
      .iCLK(iCLK), .iRST(iRST), .iEN(iEN), .iIN(iIN), .iCLR(iCLR),
      .oMATCH(match_w[3]), .oCOUNT(cnt_w[3]), .oOVF(ovf_w[3]));

   // ---------------- reference model ----------------
   task automatic model_reset();
      for (int i = 0; i < NI; i++) begin
         hist_m[i].delete();
         since_clr_m[i] = 0;
      end
   endtask

   task automatic model_push(input logic en, input logic in, input logic clr);
      for (int i = 0; i < NI; i++) begin
         bit          mt;
         int          n;
         int          c;
         bit          ov;
         logic [15:0] p;
         p  = PAT[i];
         mt = 1'b0;
         if (en) begin
            hist_m[i].push_back(in);
            n = hist_m[i].size();
            if (n >= PW[i]) begin
               mt = 1'b1;
               for (int k = 0; k < PW[i]; k++)
                  if (hist_m[i][n - PW[i] + k] != p[PW[i] - 1 - k]) mt = 1'b0;
            end
            if (mt && !OVL[i]) hist_m[i].delete();
            if (hist_m[i].size() > 16) void'(hist_m[i].pop_front());
         end
         if (clr) since_clr_m[i] = 0;
         else if (mt) since_clr_m[i]++;
         ov = (since_clr_m[i] > MAXC[i]);
         c  = ov ? MAXC[i] : since_clr_m[i];
         exp_q[i].push_back({mt, ov, 8'(c)});
      end
   endtask

   // ---------------- scoreboard monitor ----------------
   always @(posedge iCLK) begin
      #1;
      for (int i = 0; i < NI; i++) begin
         if (exp_q[i].size() > 0) begin
            mon_e = exp_q[i].pop_front();
            tests_run++;
            if (match_w[i] !== mon_e[9]) begin
               tests_failed++;
               $display("FAIL sb_match inst%0d t=%0t: got %b expected %b", i, $time, match_w[i], mon_e[9]);
            end
            tests_run++;
            if (ovf_w[i] !== mon_e[8]) begin
               tests_failed++;
               $display("FAIL sb_ovf inst%0d t=%0t: got %b expected %b", i, $time, ovf_w[i], mon_e[8]);
            end
            tests_run++;
            if (cnt_w[i] !== mon_e[7:0]) begin
               tests_failed++;
               $display("FAIL sb_count inst%0d t=%0t: got %0d expected %0d", i, $time, cnt_w[i], mon_e[7:0]);
            end
         end
      end
   end

   // ---------------- driver ----------------
   task automatic step(input logic en, input logic in, input logic clr);
      @(negedge iCLK);
      iEN  = en;
      iIN  = in;
      iCLR = clr;
      model_push(en, in, clr);
      @(posedge iCLK);
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      iRST = 1'b0; iEN = 1'b0; iIN = 1'b0; iCLR = 1'b0;
      model_reset();
      #1;
      for (int i = 0; i < NI; i++) begin
         tests_run++;
         if (match_w[i] !== 1'b0 || cnt_w[i] !== 8'd0 || ovf_w[i] !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_state inst%0d: got m=%b c=%0d o=%b expected 0/0/0", i, match_w[i], cnt_w[i], ovf_w[i]);
         end
      end
      // Reset must dominate clock edges that carry valid bits.
      iEN = 1'b1; iIN = 1'b1;
      repeat (3) @(posedge iCLK);
      #1;
      for (int i = 0; i < NI; i++) begin
         tests_run++;
         if (match_w[i] !== 1'b0 || cnt_w[i] !== 8'd0) begin
            tests_failed++;
            $display("FAIL reset_hold inst%0d: got m=%b c=%0d expected 0/0", i, match_w[i], cnt_w[i]);
         end
      end
      @(negedge iCLK);
      iRST = 1'b1; iEN = 1'b0;
      model_push(1'b0, 1'b0, 1'b0);
      @(posedge iCLK);
      // All-zero pattern: three zeros must not match, the fourth must.
      for (int b = 0; b < 4; b++) begin
         step(1'b1, 1'b0, 1'b0);
         #2;
         tests_run++;
         if (match_w[3] !== (b == 3)) begin
            tests_failed++;
            $display("FAIL zero_pattern bit%0d: got %b expected %b", b, match_w[3], (b == 3));
         end
      end
   endtask

   task automatic test_basic();
      logic [4:0] s;
      s = 5'b10101;
      for (int b = 0; b < 5; b++) begin
         step(1'b1, s[4 - b], 1'b0);
         #2;
         if (b == 2 || b == 4) begin
            tests_run++;
            if (match_w[0] !== 1'b1) begin
               tests_failed++;
               $display("FAIL basic_overlap_match bit%0d: got %b expected 1", b + 1, match_w[0]);
            end
            tests_run++;
            if (match_w[1] !== (b == 2)) begin
               tests_failed++;
               $display("FAIL basic_nonoverlap_match bit%0d: got %b expected %b", b + 1, match_w[1], (b == 2));
            end
         end
      end
      tests_run++;
      if (cnt_w[0] !== 8'd2 || cnt_w[1] !== 8'd1) begin
         tests_failed++;
         $display("FAIL basic_counts: got %0d/%0d expected 2/1", cnt_w[0], cnt_w[1]);
      end
   endtask

   task automatic test_gaps();
      step(1'b1, 1'b1, 1'b0);
      for (int g = 0; g < 1; g++) step(1'b0, 1'b1, 1'b0);
      step(1'b1, 1'b0, 1'b0);
      for (int g = 0; g < 3; g++) begin
         step(1'b0, 1'b1, 1'b0);
         #2;
         tests_run++;
         if (match_w[0] !== 1'b0) begin
            tests_failed++;
            $display("FAIL gap_no_match gap%0d: got %b expected 0", g, match_w[0]);
         end
      end
      step(1'b1, 1'b1, 1'b0);
      #2;
      tests_run++;
      if (match_w[0] !== 1'b1 || match_w[1] !== 1'b1) begin
         tests_failed++;
         $display("FAIL gap_match: got %b/%b expected 1/1", match_w[0], match_w[1]);
      end
      step(1'b0, 1'b1, 1'b0);
      #2;
      tests_run++;
      if (match_w[0] !== 1'b0) begin
         tests_failed++;
         $display("FAIL gap_strobe_width: got %b expected 0", match_w[0]);
      end
   endtask

   task automatic test_saturate();
      logic [1:0] exp_c [5];
      logic       exp_o [5];
      int         m;
      exp_c = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
      exp_o = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
      step(1'b0, 1'b0, 1'b1);
      m = 0;
      for (int b = 0; b < 11; b++) begin
         step(1'b1, ~b[0], 1'b0);
         #2;
         if (b >= 2 && b[0] == 1'b0) begin
            tests_run++;
            if (cnt_small !== exp_c[m] || ovf_w[2] !== exp_o[m]) begin
               tests_failed++;
               $display("FAIL sat_match%0d: got c=%0d o=%b expected c=%0d o=%b", m + 1, cnt_small, ovf_w[2], exp_c[m], exp_o[m]);
            end
            m++;
         end
      end
      step(1'b0, 1'b0, 1'b1);
      #2;
      tests_run++;
      if (cnt_small !== 2'd0 || ovf_w[2] !== 1'b0) begin
         tests_failed++;
         $display("FAIL sat_clear: got c=%0d o=%b expected 0/0", cnt_small, ovf_w[2]);
      end
   endtask

   task automatic test_clr_match();
      step(1'b1, 1'b1, 1'b0);
      step(1'b1, 1'b0, 1'b0);
      step(1'b1, 1'b1, 1'b1);
      #2;
      tests_run++;
      if (match_w[0] !== 1'b1 || cnt_w[0] !== 8'd0 || ovf_w[0] !== 1'b0) begin
         tests_failed++;
         $display("FAIL clr_with_match: got m=%b c=%0d o=%b expected 1/0/0", match_w[0], cnt_w[0], ovf_w[0]);
      end
   endtask

   task automatic test_reset_mid();
      step(1'b1, 1'b1, 1'b0);
      step(1'b1, 1'b0, 1'b0);
      #3;
      iRST = 1'b0;
      model_reset();
      #1;
      for (int i = 0; i < NI; i++) begin
         tests_run++;
         if (match_w[i] !== 1'b0 || cnt_w[i] !== 8'd0 || ovf_w[i] !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_async inst%0d: got m=%b c=%0d o=%b expected 0/0/0", i, match_w[i], cnt_w[i], ovf_w[i]);
         end
      end
      @(negedge iCLK);
      iRST = 1'b1; iEN = 1'b0;
      model_push(1'b0, 1'b0, 1'b0);
      @(posedge iCLK);
      step(1'b1, 1'b1, 1'b0);
      #2;
      tests_run++;
      if (match_w[0] !== 1'b0 || match_w[1] !== 1'b0) begin
         tests_failed++;
         $display("FAIL reset_trailing_bit: got %b/%b expected 0/0", match_w[0], match_w[1]);
      end
      step(1'b1, 1'b1, 1'b0);
      step(1'b1, 1'b0, 1'b0);
      step(1'b1, 1'b1, 1'b0);
      #2;
      tests_run++;
      if (match_w[0] !== 1'b1 || cnt_w[0] !== 8'd1) begin
         tests_failed++;
         $display("FAIL reset_then_match: got m=%b c=%0d expected 1/1", match_w[0], cnt_w[0]);
      end
   endtask

   task automatic test_back_to_back();
      for (int n = 0; n < 300; n++)
         step($urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)), $urandom_range(0, 31) == 0);
      step(1'b0, 1'b0, 1'b0);
   endtask

   // ---------------- sequence / report ----------------
   initial begin
      test_reset();
      test_basic();
      test_gaps();
      test_saturate();
      test_clr_match();
      test_reset_mid();
      test_back_to_back();
      @(negedge iCLK);
      for (int i = 0; i < NI; i++) begin
         tests_run++;
         if (exp_q[i].size() != 0) begin
            tests_failed++;
            $display("FAIL sb_drain inst%0d: got %0d pending expected 0", i, exp_q[i].size());
         end
      end
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

   initial begin
      #1_000_000;
      tests_failed++;
      $display("FAIL watchdog: got timeout expected completion");
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $fatal(1, "watchdog");
   end

endmodule
